// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready handshake and
// feeds the fetch/decode register, with a one-word hold buffer for decode stalls.
module if_fetch_stage #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  branch,
  input  logic [WORD_WIDTH-1:0] branch_target,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] instr_dec,
  output logic [WORD_WIDTH-1:0] pc_dec,
  output logic                  fetch_valid
);

  typedef enum logic [1:0] {START, FETCH, WAIT, HOLD} state_t;
  typedef enum logic [1:0] {OUT_HOLD, OUT_LOAD, OUT_BUBBLE} out_t;

  localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(4);
  localparam logic [WORD_WIDTH-1:0] ALIGN   = ~WORD_WIDTH'(3);

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] pc, pc_nxt;
  logic [WORD_WIDTH-1:0] buf_instr, buf_pc;
  out_t                  out_kind;
  logic [WORD_WIDTH-1:0] ld_instr, ld_pc;
  logic                  capture;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= START;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (branch) state_nxt = FETCH;
    else begin
      case (state)
        START: state_nxt = FETCH;
        FETCH: if (!stall && !imem_ready) state_nxt = WAIT;
        WAIT:  if (imem_ready) state_nxt = stall ? HOLD : FETCH;
        HOLD:  if (!stall) state_nxt = FETCH;
        default: state_nxt = START;
      endcase
    end
  end

  // Once a WAIT request is up it stays up through stalls so the address never moves.
  always_comb begin
    imem_req = 1'b0;
    case (state)
      FETCH:   imem_req = ~stall;
      WAIT:    imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
    if (branch) imem_req = 1'b0;
  end

  always_comb begin
    out_kind = OUT_HOLD;
    ld_instr = imem_rdata;
    ld_pc    = pc;
    pc_nxt   = pc;
    capture  = 1'b0;
    if (branch) begin
      out_kind = OUT_BUBBLE;
      pc_nxt   = branch_target & ALIGN;
    end else begin
      case (state)
        FETCH: if (!stall) begin
          out_kind = imem_ready ? OUT_LOAD : OUT_BUBBLE;
          if (imem_ready) pc_nxt = pc + PC_STEP;
        end
        WAIT: begin
          if (imem_ready) begin
            pc_nxt   = pc + PC_STEP;
            capture  = stall;
            out_kind = stall ? OUT_HOLD : OUT_LOAD;
          end else if (!stall) begin
            out_kind = OUT_BUBBLE;
          end
        end
        HOLD: if (!stall) begin
          out_kind = OUT_LOAD;
          ld_instr = buf_instr;
          ld_pc    = buf_pc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      instr_dec   <= '0;
      pc_dec      <= '0;
      fetch_valid <= 1'b0;
      buf_instr   <= '0;
      buf_pc      <= '0;
    end else begin
      pc <= pc_nxt;
      if (capture) begin
        buf_instr <= imem_rdata;
        buf_pc    <= pc;
      end
      case (out_kind)
        OUT_LOAD: begin
          instr_dec   <= ld_instr;
          pc_dec      <= ld_pc;
          fetch_valid <= 1'b1;
        end
        OUT_BUBBLE: begin
          instr_dec   <= '0;
          pc_dec      <= '0;
          fetch_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;

endmodule
